population_count_accumulator: RTL

POPULATION_COUNT_ACCUMULATOR -- requirements
Module: population_count_accumulator

---
 rtl/population_count.sv | 18 +
 rtl/population_count_accumulator.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/population_count.sv
// Combinational population count of one chunk.
// Used once per chunk by population_count_accumulator.
module Population_Count #(
  parameter int WORD_WIDTH     = 4,
  parameter int POPCOUNT_WIDTH = 3
) (
  input  logic [WORD_WIDTH-1:0]     word,
  output logic [POPCOUNT_WIDTH-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      count = count + POPCOUNT_WIDTH'(word[i]);
    end
  end

endmodule

// File: rtl/population_count_accumulator.sv
// Two-stage popcount pipeline with a saturating running total.
// Stage 1 registers per-chunk counts; stage 2 sums them and updates the total.
module population_count_accumulator #(
  parameter int WORD_WIDTH     = 16,
  parameter int CHUNK_WIDTH    = 4,
  parameter int POPCOUNT_WIDTH = 5,
  parameter int TOTAL_WIDTH    = 8
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      input_valid,
  output logic                      input_ready,
  input  logic [WORD_WIDTH-1:0]     input_data,
  input  logic                      input_start,
  input  logic                      input_invert,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [POPCOUNT_WIDTH-1:0] output_count,
  output logic [TOTAL_WIDTH-1:0]    output_total,
  output logic                      output_saturated
);

  localparam int NUM_CHUNKS        = (WORD_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int PADDED_WIDTH      = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int PAD_WIDTH         = PADDED_WIDTH - WORD_WIDTH;
  localparam int CHUNK_COUNT_WIDTH = $clog2(CHUNK_WIDTH + 1);
  localparam int SUM_WIDTH         = TOTAL_WIDTH + 1;

  logic                         advance;
  logic [WORD_WIDTH-1:0]        masked_word;
  logic [PADDED_WIDTH-1:0]      padded_word;
  logic [CHUNK_COUNT_WIDTH-1:0] chunk_count [NUM_CHUNKS];

  logic                         s1_valid_d, s1_valid_q;
  logic                         s1_start_d, s1_start_q;
  logic [CHUNK_COUNT_WIDTH-1:0] chunk_count_d [NUM_CHUNKS];
  logic [CHUNK_COUNT_WIDTH-1:0] chunk_count_q [NUM_CHUNKS];

  logic                         out_valid_d, out_valid_q;
  logic [POPCOUNT_WIDTH-1:0]    out_count_d, out_count_q;
  logic [TOTAL_WIDTH-1:0]       out_total_d, out_total_q;
  logic                         out_sat_d, out_sat_q;

  logic [POPCOUNT_WIDTH-1:0]    word_count;
  logic [TOTAL_WIDTH-1:0]       total_base;
  logic [SUM_WIDTH-1:0]         total_sum;
  logic                         total_clamp;
  logic [TOTAL_WIDTH-1:0]       total_next;

  // One enable moves both stages, so a stalled output freezes the whole pipe.
  assign advance     = !out_valid_q || output_ready;
  assign input_ready = advance;

  // Padding is inserted after the invert so pad bits always read as zero.
  assign masked_word = input_data ^ {WORD_WIDTH{input_invert}};
  assign padded_word = PADDED_WIDTH'(masked_word);

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
    Population_Count #(
      .WORD_WIDTH    (CHUNK_WIDTH),
      .POPCOUNT_WIDTH(CHUNK_COUNT_WIDTH)
    ) u_chunk_count (
      .word (padded_word[g*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .count(chunk_count[g])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_start_d = s1_start_q;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      chunk_count_d[i] = chunk_count_q[i];
    end
    if (advance) begin
      s1_valid_d = input_valid;
      s1_start_d = input_start;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        chunk_count_d[i] = chunk_count[i];
      end
    end
  end

  always_comb begin
    word_count = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      word_count = word_count + POPCOUNT_WIDTH'(chunk_count_q[i]);
    end
  end

  // Total never exceeds its max and the count fits in TOTAL_WIDTH, so one
  // extra sum bit is enough to flag overflow.
  always_comb begin
    total_base  = s1_start_q ? '0 : out_total_q;
    total_sum   = SUM_WIDTH'(total_base) + SUM_WIDTH'(word_count);
    total_clamp = total_sum[TOTAL_WIDTH];
    total_next  = total_clamp ? {TOTAL_WIDTH{1'b1}} : total_sum[TOTAL_WIDTH-1:0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_total_d = out_total_q;
    out_sat_d   = out_sat_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_count_d = word_count;
        out_total_d = total_next;
        out_sat_d   = s1_start_q ? total_clamp : (out_sat_q || total_clamp);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      s1_valid_q  <= 1'b0;
      s1_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_total_q <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        chunk_count_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_start_q  <= s1_start_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_total_q <= out_total_d;
      out_sat_q   <= out_sat_d;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        chunk_count_q[i] <= chunk_count_d[i];
      end
    end
  end

  assign output_valid     = out_valid_q;
  assign output_count     = out_count_q;
  assign output_total     = out_total_q;
  assign output_saturated = out_sat_q;

endmodule
